// File: rtl/game_pkg.sv
// Definitions shared by the game state FSM and the score counter:
// the state encoding and the score ceiling that doubles as the WIN threshold.
package game_pkg;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    RUN  = 3'd1,
    OVER = 3'd2,
    WIN  = 3'd3
  } state_t;

  localparam int unsigned MAX_SCORE = 99;
  localparam logic [3:0]  MAX_TENS  = 4'(MAX_SCORE / 10);
  localparam logic [3:0]  MAX_ONES  = 4'(MAX_SCORE % 10);

endpackage

// File: rtl/score_tick_gen.sv
// Prescaler producing one score tick every TICK_DIV cycles while enabled.
// The counter is held at zero when disabled so each enable starts a full period.
module score_tick_gen #(
  parameter int unsigned TICK_DIV = 1_000_000
) (
  input  logic clk,
  input  logic reset,
  input  logic enable,
  output logic tick
);

  localparam int unsigned    CW   = $clog2(TICK_DIV);
  localparam logic [CW-1:0]  LAST = CW'(TICK_DIV - 1);

  logic [CW-1:0] div_cnt_q, div_cnt_d;

  assign tick = enable && (div_cnt_q == LAST);

  always_comb begin
    div_cnt_d = div_cnt_q;
    if (!enable) begin
      div_cnt_d = '0;
    end else if (tick) begin
      div_cnt_d = '0;
    end else begin
      div_cnt_d = div_cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      div_cnt_q <= '0;
    end else begin
      div_cnt_q <= div_cnt_d;
    end
  end

endmodule

// File: rtl/score_counter.sv
// Game score: time ticks plus obstacle bonuses during RUN, saturating at MAX_SCORE,
// with registered BCD digits for the display and a session high score.
module score_counter
  import game_pkg::*;
#(
  parameter int unsigned TICK_DIV = 1_000_000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [2:0] game_state,
  input  logic       obstacle_passed,
  output logic [6:0] score,
  output logic [3:0] score_tens,
  output logic [3:0] score_ones,
  output logic [6:0] hi_score,
  output logic       new_high,
  output logic       score_max
);

  logic [2:0] prev_state_q;
  logic [6:0] score_q, score_d;
  logic [3:0] tens_q, tens_d;
  logic [3:0] ones_q, ones_d;
  logic [6:0] hi_q, hi_d;
  logic       new_high_q, new_high_d;
  logic       score_max_q, score_max_d;

  logic       in_run, in_idle, tick;
  logic [1:0] inc;
  logic [7:0] sum;
  logic [4:0] ones_sum;

  assign in_run  = (game_state == RUN);
  assign in_idle = (game_state == IDLE);

  score_tick_gen #(.TICK_DIV(TICK_DIV)) u_tick (
    .clk    (clk),
    .reset  (reset),
    .enable (in_run),
    .tick   (tick)
  );

  // Sum is 8 bits so 98+2 can be seen before clamping back to MAX_SCORE.
  assign inc      = {1'b0, tick} + {1'b0, obstacle_passed};
  assign sum      = {1'b0, score_q} + {6'b0, inc};
  assign ones_sum = {1'b0, ones_q} + {3'b0, inc};

  always_comb begin
    score_d     = score_q;
    tens_d      = tens_q;
    ones_d      = ones_q;
    hi_d        = hi_q;
    new_high_d  = new_high_q;
    score_max_d = 1'b0;

    if (in_idle) begin
      score_d = '0;
      tens_d  = '0;
      ones_d  = '0;
    end else if (in_run) begin
      if (sum >= 8'(MAX_SCORE)) begin
        score_d = 7'(MAX_SCORE);
        tens_d  = MAX_TENS;
        ones_d  = MAX_ONES;
      end else begin
        score_d = sum[6:0];
        if (ones_sum >= 5'd10) begin
          ones_d = 4'(ones_sum - 5'd10);
          tens_d = tens_q + 4'd1;
        end else begin
          ones_d = ones_sum[3:0];
        end
      end
      score_max_d = (score_d == 7'(MAX_SCORE)) && (score_q != 7'(MAX_SCORE));
    end

    // Leaving RUN commits the finished run; a tie does not count as a new record.
    if ((prev_state_q == RUN) && !in_run && (score_q > hi_q)) begin
      hi_d       = score_q;
      new_high_d = 1'b1;
    end
    if ((prev_state_q == IDLE) && in_run) begin
      new_high_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      prev_state_q <= IDLE;
      score_q      <= '0;
      tens_q       <= '0;
      ones_q       <= '0;
      hi_q         <= '0;
      new_high_q   <= 1'b0;
      score_max_q  <= 1'b0;
    end else begin
      prev_state_q <= game_state;
      score_q      <= score_d;
      tens_q       <= tens_d;
      ones_q       <= ones_d;
      hi_q         <= hi_d;
      new_high_q   <= new_high_d;
      score_max_q  <= score_max_d;
    end
  end

  assign score      = score_q;
  assign score_tens = tens_q;
  assign score_ones = ones_q;
  assign hi_score   = hi_q;
  assign new_high   = new_high_q;
  assign score_max  = score_max_q;

endmodule
